// File: rtl/top_link.sv
// top_link: FIFO-buffered asynchronous serial link with independent TX and RX.
// Optional even parity bit between data and stop bits: define TOP_LINK_PARITY_EN.
module top_link #(
    parameter int width_p = 10,
    parameter int depth_p = 4,
    parameter int div_p   = 4
) (
    input  logic               main_clk_i,
    input  logic               main_rst_i,
    input  logic [width_p-1:0] tx_data_i,
    input  logic               tx_valid_i,
    output logic               tx_ready_o,
    output logic [width_p-1:0] rx_data_o,
    output logic               rx_valid_o,
    output logic               rx_err_o,
    input  logic               intf_rx_i,
    output logic               intf_tx_o
);

    localparam int AW = (depth_p > 1) ? $clog2(depth_p) : 1;
    localparam int CW = $clog2(div_p);
    localparam int BW = (width_p > 1) ? $clog2(width_p) : 1;
    localparam logic [CW-1:0] DIV_LAST  = CW'(div_p - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(div_p / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(width_p - 1);
    localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(depth_p);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
`ifdef TOP_LINK_PARITY_EN
        ST_PARITY,
`endif
        ST_STOP
    } state_t;

    // ---------------- TX FIFO ----------------
    logic [width_p-1:0] mem [depth_p];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [AW:0]        count;
    logic               full;
    logic               empty;
    logic               push;
    logic               take;
    logic               avail;
    logic               fifo_wr;
    logic               fifo_rd;
    logic [width_p-1:0] src;

    assign full       = (count == FIFO_FULL);
    assign empty      = (count == '0);
    assign tx_ready_o = !full;
    assign push       = tx_valid_i && !full;
    // A word pushed into an empty FIFO can go straight to the shifter.
    assign avail      = !empty || push;
    assign src        = empty ? tx_data_i : mem[rd_ptr];
    assign fifo_wr    = push && !(take && empty);
    assign fifo_rd    = take && !empty;

    // FIFO storage write port
    always_ff @(posedge main_clk_i) begin
        if (fifo_wr) begin
            mem[wr_ptr] <= tx_data_i;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
            if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{AW{1'b0}}, fifo_wr} - {{AW{1'b0}}, fifo_rd};
        end
    end

    // ---------------- TX FSM ----------------
    state_t             tx_state, tx_state_d;
    logic [CW-1:0]      tx_cnt, tx_cnt_d;
    logic [BW-1:0]      tx_bit, tx_bit_d;
    logic [width_p-1:0] tx_sh, tx_sh_d;
    logic               tx_line_d;
`ifdef TOP_LINK_PARITY_EN
    logic               tx_par, tx_par_d;
`endif

    // TX state, counters, shifter and registered serial line
    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            tx_state  <= ST_IDLE;
            tx_cnt    <= '0;
            tx_bit    <= '0;
            tx_sh     <= '0;
            intf_tx_o <= 1'b1;
`ifdef TOP_LINK_PARITY_EN
            tx_par    <= 1'b0;
`endif
        end else begin
            tx_state  <= tx_state_d;
            tx_cnt    <= tx_cnt_d;
            tx_bit    <= tx_bit_d;
            tx_sh     <= tx_sh_d;
            intf_tx_o <= tx_line_d;
`ifdef TOP_LINK_PARITY_EN
            tx_par    <= tx_par_d;
`endif
        end
    end

    // TX next state; line value follows the state being entered
    always_comb begin
        tx_state_d = tx_state;
        tx_cnt_d   = tx_cnt + 1'b1;
        tx_bit_d   = tx_bit;
        tx_sh_d    = tx_sh;
        tx_line_d  = intf_tx_o;
        take       = 1'b0;
`ifdef TOP_LINK_PARITY_EN
        tx_par_d   = tx_par;
`endif
        unique case (tx_state)
            ST_IDLE: begin
                tx_cnt_d  = '0;
                tx_line_d = 1'b1;
                if (avail) begin
                    take       = 1'b1;
                    tx_sh_d    = src;
                    tx_state_d = ST_START;
                    tx_line_d  = 1'b0;
`ifdef TOP_LINK_PARITY_EN
                    tx_par_d   = ^src;
`endif
                end
            end
            ST_START: begin
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_d   = '0;
                    tx_bit_d   = '0;
                    tx_state_d = ST_DATA;
                    tx_line_d  = tx_sh[0];
                end
            end
            ST_DATA: begin
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_d = '0;
                    if (tx_bit == BIT_LAST) begin
`ifdef TOP_LINK_PARITY_EN
                        tx_state_d = ST_PARITY;
                        tx_line_d  = tx_par;
`else
                        tx_state_d = ST_STOP;
                        tx_line_d  = 1'b1;
`endif
                    end else begin
                        tx_bit_d  = tx_bit + 1'b1;
                        tx_sh_d   = tx_sh >> 1;
                        tx_line_d = tx_sh_d[0];
                    end
                end
            end
`ifdef TOP_LINK_PARITY_EN
            ST_PARITY: begin
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_d   = '0;
                    tx_state_d = ST_STOP;
                    tx_line_d  = 1'b1;
                end
            end
`endif
            ST_STOP: begin
                if (tx_cnt == DIV_LAST) begin
                    tx_cnt_d = '0;
                    if (avail) begin
                        take       = 1'b1;
                        tx_sh_d    = src;
                        tx_state_d = ST_START;
                        tx_line_d  = 1'b0;
`ifdef TOP_LINK_PARITY_EN
                        tx_par_d   = ^src;
`endif
                    end else begin
                        tx_state_d = ST_IDLE;
                        tx_line_d  = 1'b1;
                    end
                end
            end
            default: begin
                tx_state_d = ST_IDLE;
                tx_line_d  = 1'b1;
            end
        endcase
    end

    // ---------------- RX ----------------
    logic               sync1, rx_s, rx_prev;
    state_t             rx_state, rx_state_d;
    logic [CW-1:0]      rx_cnt, rx_cnt_d;
    logic [BW-1:0]      rx_bit, rx_bit_d;
    logic [width_p-1:0] rx_sh, rx_sh_d;
    logic               rx_valid_d;
    logic               rx_err_d;
    logic [width_p-1:0] rx_data_d;
`ifdef TOP_LINK_PARITY_EN
    logic               rx_perr, rx_perr_d;
`endif

    // Two-flop synchronizer plus one delay stage for edge detection
    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            sync1   <= 1'b1;
            rx_s    <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            sync1   <= intf_rx_i;
            rx_s    <= sync1;
            rx_prev <= rx_s;
        end
    end

    // RX state, counters, shifter and output registers
    always_ff @(posedge main_clk_i or posedge main_rst_i) begin
        if (main_rst_i) begin
            rx_state   <= ST_IDLE;
            rx_cnt     <= '0;
            rx_bit     <= '0;
            rx_sh      <= '0;
            rx_valid_o <= 1'b0;
            rx_err_o   <= 1'b0;
            rx_data_o  <= '0;
`ifdef TOP_LINK_PARITY_EN
            rx_perr    <= 1'b0;
`endif
        end else begin
            rx_state   <= rx_state_d;
            rx_cnt     <= rx_cnt_d;
            rx_bit     <= rx_bit_d;
            rx_sh      <= rx_sh_d;
            rx_valid_o <= rx_valid_d;
            rx_err_o   <= rx_err_d;
            rx_data_o  <= rx_data_d;
`ifdef TOP_LINK_PARITY_EN
            rx_perr    <= rx_perr_d;
`endif
        end
    end

    // RX next state: mid-bit sampling anchored on the start bit centre
    always_comb begin
        rx_state_d = rx_state;
        rx_cnt_d   = rx_cnt + 1'b1;
        rx_bit_d   = rx_bit;
        rx_sh_d    = rx_sh;
        rx_valid_d = 1'b0;
        rx_err_d   = rx_err_o;
        rx_data_d  = rx_data_o;
`ifdef TOP_LINK_PARITY_EN
        rx_perr_d  = rx_perr;
`endif
        unique case (rx_state)
            ST_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev && !rx_s) begin
                    rx_state_d = ST_START;
                end
            end
            ST_START: begin
                if (rx_cnt == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_s ? ST_IDLE : ST_DATA;
                end
            end
            ST_DATA: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_d = '0;
                    rx_sh_d  = {rx_s, rx_sh[width_p-1:1]};
                    if (rx_bit == BIT_LAST) begin
`ifdef TOP_LINK_PARITY_EN
                        rx_state_d = ST_PARITY;
`else
                        rx_state_d = ST_STOP;
`endif
                    end else begin
                        rx_bit_d = rx_bit + 1'b1;
                    end
                end
            end
`ifdef TOP_LINK_PARITY_EN
            ST_PARITY: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_perr_d  = rx_s ^ (^rx_sh);
                    rx_state_d = ST_STOP;
                end
            end
`endif
            ST_STOP: begin
                if (rx_cnt == DIV_LAST) begin
                    rx_cnt_d   = '0;
                    rx_valid_d = 1'b1;
                    rx_data_d  = rx_sh;
`ifdef TOP_LINK_PARITY_EN
                    rx_err_d   = !rx_s || rx_perr;
`else
                    rx_err_d   = !rx_s;
`endif
                    rx_state_d = ST_IDLE;
                end
            end
            default: begin
                rx_state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_top_link.sv
// tb_top_link: vector table, hand sequences and a random loopback run
// against an in-order word model for top_link.
`timescale 1ns/1ps
module tb_top_link;

    localparam int W   = 10;
    localparam int DIV = 4;
`ifdef TOP_LINK_PARITY_EN
    localparam int NB = W + 3;
`else
    localparam int NB = W + 2;
`endif
    localparam int FC = NB * DIV;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] tx_data = '0;
    logic         tx_valid = 1'b0;
    logic         tx_ready;
    logic [W-1:0] rx_data;
    logic         rx_valid;
    logic         rx_err;
    logic         intf_tx;
    logic         rx_line;
    logic         loop = 1'b1;
    logic         rx_drv = 1'b1;

    assign rx_line = loop ? intf_tx : rx_drv;

    top_link #(.width_p(W), .depth_p(4), .div_p(DIV)) dut (
        .main_clk_i(clk),
        .main_rst_i(rst),
        .tx_data_i (tx_data),
        .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready),
        .rx_data_o (rx_data),
        .rx_valid_o(rx_valid),
        .rx_err_o  (rx_err),
        .intf_rx_i (rx_line),
        .intf_tx_o (intf_tx)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] d;
        logic         e;
        int           t;
    } rx_t;

    typedef struct {
        logic [W-1:0] d;
        logic [12:0]  f;
    } vec_t;

    rx_t          rx_q[$];
    logic [W-1:0] exp_q[$];
    vec_t         tbl[5];
    int           checks = 0;
    int           errors = 0;
    int           cyc = 0;

    always @(negedge clk) begin
        cyc++;
        if (rx_valid) rx_q.push_back('{rx_data, rx_err, cyc});
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_rx(input int n, input int lim);
        int c = 0;
        while (rx_q.size() < n && c < lim) begin
            @(negedge clk);
            c++;
        end
        chk("rx_count", rx_q.size(), n);
    endtask

    task automatic chk_rx(input string name, input logic [W-1:0] d,
                          input logic e);
        rx_t r;
        if (rx_q.size() == 0) begin
            chk(name, 64'hdead, {d, e});
        end else begin
            r = rx_q.pop_front();
            chk(name, {r.d, r.e}, {d, e});
        end
    endtask

    task automatic send_raw(input logic [W-1:0] d, input logic p,
                            input logic s);
        logic [W+2:0] full;
        full = {s, p, d, 1'b0};
        for (int b = 0; b < NB; b++) begin
            rx_drv = (NB == W + 2 && b == W + 1) ? s : full[b];
            repeat (DIV) @(negedge clk);
        end
        rx_drv = 1'b1;
    endtask

    initial begin
        logic [63:0] obs;
        logic [63:0] expw;
        logic [W-1:0] acc[$];
        rx_t r0, r1, r2;
        int n;
        int sent;
        int t;

`ifdef TOP_LINK_PARITY_EN
        tbl[0] = '{10'h2A5, 13'h1D4A};
        tbl[1] = '{10'h000, 13'h1000};
        tbl[2] = '{10'h3FF, 13'h17FE};
        tbl[3] = '{10'h155, 13'h1AAA};
        tbl[4] = '{10'h001, 13'h1802};
`else
        tbl[0] = '{10'h2A5, 13'h0D4A};
        tbl[1] = '{10'h000, 13'h0800};
        tbl[2] = '{10'h3FF, 13'h0FFE};
        tbl[3] = '{10'h155, 13'h0AAA};
        tbl[4] = '{10'h001, 13'h0802};
`endif

        #1 rst = 1'b1;
        #11;
        chk("rst_tx", intf_tx, 1);
        chk("rst_ready", tx_ready, 1);
        chk("rst_valid", rx_valid, 0);
        chk("rst_err", rx_err, 0);
        chk("rst_data", rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Vector table: serial waveform, return to idle, loopback receive
        for (int i = 0; i < 5; i++) begin
            rx_q.delete();
            @(negedge clk);
            tx_data  = tbl[i].d;
            tx_valid = 1'b1;
            @(negedge clk);
            tx_valid = 1'b0;
            obs  = '0;
            expw = '0;
            for (int k = 0; k < FC; k++) begin
                obs[k]  = intf_tx;
                expw[k] = tbl[i].f[k / DIV];
                if (k < FC - 1) @(negedge clk);
            end
            chk("tx_wave", obs, expw);
            @(negedge clk);
            chk("tx_idle", intf_tx, 1);
            wait_rx(1, 20);
            chk_rx("tbl_rx", tbl[i].d, 1'b0);
        end

        // Back-to-back frames: no gap on the line or between pulses
        rx_q.delete();
        @(negedge clk); tx_data = 10'h000; tx_valid = 1'b1;
        @(negedge clk); tx_data = 10'h3FF;
        @(negedge clk); tx_data = 10'h155;
        @(negedge clk); tx_valid = 1'b0;
        wait_rx(3, 3 * FC + 40);
        if (rx_q.size() == 3) begin
            r0 = rx_q[0];
            r1 = rx_q[1];
            r2 = rx_q[2];
            chk("b2b_gap1", r1.t - r0.t, FC);
            chk("b2b_gap2", r2.t - r1.t, FC);
        end
        chk_rx("b2b_rx0", 10'h000, 1'b0);
        chk_rx("b2b_rx1", 10'h3FF, 1'b0);
        chk_rx("b2b_rx2", 10'h155, 1'b0);

        // Hold valid for 7 cycles from idle: 5 accepted, ready low a frame
        rx_q.delete();
        repeat (4) @(negedge clk);
        for (int i = 0; i < 7; i++) begin
            if (i > 0) @(negedge clk);
            tx_data  = W'(10'h100 + i);
            tx_valid = 1'b1;
            if (tx_ready) acc.push_back(tx_data);
        end
        @(negedge clk);
        tx_valid = 1'b0;
        chk("hold_accepted", acc.size(), 5);
        chk("hold_ready_low", tx_ready, 0);
        n = 7;
        while (!tx_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("hold_ready_rise", n, FC + 1);
        chk("hold_no_gap", intf_tx, 0);
        wait_rx(5, 5 * FC + 40);
        for (int i = 0; i < 5; i++) begin
            if (acc.size() > 0) chk_rx("hold_rx", acc.pop_front(), 1'b0);
        end

        // Random loopback traffic against an in-order word model
        rx_q.delete();
        exp_q.delete();
        sent = 0;
        t = 0;
        while (sent < 24 && t < 5000) begin
            @(negedge clk);
            t++;
            if ($urandom_range(0, 3) != 0) begin
                tx_valid = 1'b1;
                tx_data  = W'($urandom);
                if (tx_ready) begin
                    exp_q.push_back(tx_data);
                    sent++;
                end
            end else begin
                tx_valid = 1'b0;
            end
        end
        @(negedge clk);
        tx_valid = 1'b0;
        chk("rand_sent", sent, 24);
        wait_rx(exp_q.size(), 26 * FC + 100);
        while (exp_q.size() > 0) chk_rx("rand_rx", exp_q.pop_front(), 1'b0);

        // Externally driven frames
        loop = 1'b0;
        repeat (10) @(negedge clk);
        rx_q.delete();
        send_raw(10'h2C9, ^10'h2C9, 1'b1);
        wait_rx(1, 20);
        chk_rx("raw_good", 10'h2C9, 1'b0);

`ifdef TOP_LINK_PARITY_EN
        repeat (5) @(negedge clk);
        send_raw(10'h001, 1'b0, 1'b1);
        wait_rx(1, 20);
        chk_rx("par_bad", 10'h001, 1'b1);
        repeat (5) @(negedge clk);
        send_raw(10'h001, 1'b1, 1'b1);
        wait_rx(1, 20);
        chk_rx("par_good", 10'h001, 1'b0);
`endif

        repeat (5) @(negedge clk);
        send_raw(10'h0F3, ^10'h0F3, 1'b0);
        wait_rx(1, 20);
        chk_rx("stop_err", 10'h0F3, 1'b1);

        repeat (10) @(negedge clk);
        rx_drv = 1'b0;
        @(negedge clk);
        rx_drv = 1'b1;
        repeat (FC + 20) @(negedge clk);
        chk("glitch_none", rx_q.size(), 0);

        // Reset in the middle of a loopback frame
        loop = 1'b1;
        rx_q.delete();
        @(negedge clk);
        tx_data  = 10'h155;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        repeat (20) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_tx", intf_tx, 1);
        chk("mid_rst_ready", tx_ready, 1);
        chk("mid_rst_valid", rx_valid, 0);
        chk("mid_rst_err", rx_err, 0);
        chk("mid_rst_data", rx_data, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (FC + 40) @(negedge clk);
        chk("mid_rst_no_rx", rx_q.size(), 0);
        chk("mid_rst_idle", intf_tx, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
